// File: rtl/r88_prefetch_if.sv
// Bundles the Rocket88 prefetch unit's memory-side and decoder-side signals.
// The master modport faces the prefetch unit; the slave modport faces its environment.
interface r88_prefetch_if;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memAck;
    logic [7:0]  memData;
    logic        flush;
    logic [15:0] flushAddr;
    logic        byteValid;
    logic [7:0]  byteData;
    logic [15:0] byteAddr;
    logic        byteTake;
    logic [3:0]  level;

    modport master (
        output memAddr, memRead, byteValid, byteData, byteAddr, level,
        input  memAck, memData, flush, flushAddr, byteTake
    );

    modport slave (
        input  memAddr, memRead, byteValid, byteData, byteAddr, level,
        output memAck, memData, flush, flushAddr, byteTake
    );
endinterface

// File: rtl/r88_prefetch.sv
// Rocket88 instruction-byte prefetch: fetches sequential bytes into a small FIFO
// for the decoder and restarts fetching at a new address on flush.
module r88_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic             sysClock,
    input logic             sysResetN,
    r88_prefetch_if.master  bus
);
    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic               mem_read_q, mem_read_d;
    logic [15:0]        saved_addr_q, saved_addr_d;
    logic [15:0]        byte_addr_q, byte_addr_d;
    logic [3:0]         level_q, level_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]         fifo_q [DEPTH];
    logic [7:0]         fifo_d [DEPTH];
    logic               push;
    logic               pop;

    always_comb begin
        push         = (state_q == REQ) && bus.memAck && !bus.flush;
        pop          = bus.byteTake && (level_q != 4'd0) && !bus.flush;

        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        byte_addr_d  = byte_addr_q;
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        saved_addr_d = saved_addr_q;

        if (push) begin
            fifo_d[wr_ptr_q] = bus.memData;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            byte_addr_d = byte_addr_q + 16'd1;
        end
        level_d = level_q + 4'(push) - 4'(pop);

        // Flush wins over any pop or push happening in the same cycle.
        if (bus.flush) begin
            level_d     = 4'd0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            byte_addr_d = bus.flushAddr;
        end

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    mem_addr_d = bus.flushAddr;
                    state_d    = REQ;
                end else if (level_d < DEPTH_L) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.flush) begin
                    if (bus.memAck) begin
                        mem_addr_d = bus.flushAddr;
                    end else begin
                        saved_addr_d = bus.flushAddr;
                        state_d      = DRAIN;
                    end
                end else if (bus.memAck) begin
                    mem_addr_d = mem_addr_q + 16'd1;
                    state_d    = (level_d < DEPTH_L) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // The outstanding bus transfer must complete; its byte is discarded.
                if (bus.flush) begin
                    saved_addr_d = bus.flushAddr;
                    if (bus.memAck) begin
                        mem_addr_d = bus.flushAddr;
                        state_d    = REQ;
                    end
                end else if (bus.memAck) begin
                    mem_addr_d = saved_addr_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_read_d = (state_d != IDLE);
    end

    always_ff @(posedge sysClock or negedge sysResetN) begin
        if (!sysResetN) begin
            state_q      <= IDLE;
            mem_addr_q   <= RESET_PC;
            mem_read_q   <= 1'b0;
            saved_addr_q <= RESET_PC;
            byte_addr_q  <= RESET_PC;
            level_q      <= 4'd0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            saved_addr_q <= saved_addr_d;
            byte_addr_q  <= byte_addr_d;
            level_q      <= level_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_q       <= fifo_d;
        end
    end

    assign bus.memAddr   = mem_addr_q;
    assign bus.memRead   = mem_read_q;
    assign bus.level     = level_q;
    assign bus.byteAddr  = byte_addr_q;
    assign bus.byteValid = (level_q != 4'd0);
    assign bus.byteData  = (level_q != 4'd0) ? fifo_q[rd_ptr_q] : 8'h00;
endmodule

// File: tb/tb_r88_prefetch.sv
// Directed bench for r88_prefetch: fill, saturation, flush/drain, address wrap,
// simultaneous push/pop and asynchronous reset mid-request.
module tb_r88_prefetch;
    logic sysClock;
    logic sysResetN;
    int   checkCount;
    int   failCount;

    r88_prefetch_if bus ();

    r88_prefetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .sysClock  (sysClock),
        .sysResetN (sysResetN),
        .bus       (bus)
    );

    // Memory image: 0000..0004 hold 11,22,33,44,55; 1234 -> 97; FFFE -> 10; FFFF -> FF.
    function automatic logic [7:0] memByte(input logic [15:0] a);
        logic [7:0] lo;
        logic [7:0] prod;
        lo   = a[7:0] + 8'd1;
        prod = lo * 8'd17;
        return prod ^ a[15:8];
    endfunction

    assign bus.memData = memByte(bus.memAddr);

    initial begin
        sysClock = 1'b0;
        forever #5 sysClock = ~sysClock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic take,
                                 input logic flsh, input logic [15:0] fAddr);
        bus.memAck    = ack;
        bus.byteTake  = take;
        bus.flush     = flsh;
        bus.flushAddr = fAddr;
    endtask

    task automatic cycle();
        @(negedge sysClock);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        sysResetN  = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        #2;
        checkOutput("rst_memRead", bus.memRead, 0);
        checkOutput("rst_memAddr", bus.memAddr, 16'h0000);
        checkOutput("rst_byteValid", bus.byteValid, 0);
        checkOutput("rst_level", bus.level, 0);
        checkOutput("rst_byteAddr", bus.byteAddr, 16'h0000);
        checkOutput("rst_byteData", bus.byteData, 8'h00);

        @(negedge sysClock);
        sysResetN = 1'b1;
        cycle();
        checkOutput("e1_memRead", bus.memRead, 1);
        checkOutput("e1_byteValid", bus.byteValid, 0);
        checkOutput("e1_memAddr", bus.memAddr, 16'h0000);
        cycle();
        checkOutput("e2_byteValid", bus.byteValid, 1);
        checkOutput("e2_byteData", bus.byteData, 8'h11);
        checkOutput("e2_byteAddr", bus.byteAddr, 16'h0000);
        checkOutput("e2_level", bus.level, 1);
        cycle();
        checkOutput("e3_level", bus.level, 2);
        cycle();
        checkOutput("e4_level", bus.level, 3);
        checkOutput("e4_memRead", bus.memRead, 1);
        cycle();
        checkOutput("full_level", bus.level, 4);
        checkOutput("full_memRead", bus.memRead, 0);
        checkOutput("full_memAddr", bus.memAddr, 16'h0004);

        cycle();
        cycle();
        checkOutput("sat_level", bus.level, 4);
        checkOutput("sat_memRead", bus.memRead, 0);
        checkOutput("sat_memAddr", bus.memAddr, 16'h0004);

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        cycle();
        checkOutput("take1_level", bus.level, 3);
        checkOutput("take1_memRead", bus.memRead, 1);
        checkOutput("take1_memAddr", bus.memAddr, 16'h0004);
        checkOutput("take1_byteData", bus.byteData, 8'h22);
        checkOutput("take1_byteAddr", bus.byteAddr, 16'h0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        checkOutput("refetch_level", bus.level, 4);
        checkOutput("refetch_memRead", bus.memRead, 0);
        checkOutput("refetch_memAddr", bus.memAddr, 16'h0005);
        cycle();
        checkOutput("once_memRead", bus.memRead, 0);
        checkOutput("once_memAddr", bus.memAddr, 16'h0005);

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle();
        checkOutput("pre_fl_memRead", bus.memRead, 1);
        checkOutput("pre_fl_level", bus.level, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
        cycle();
        checkOutput("fl_memRead", bus.memRead, 1);
        checkOutput("fl_memAddr", bus.memAddr, 16'h0005);
        checkOutput("fl_level", bus.level, 0);
        checkOutput("fl_byteAddr", bus.byteAddr, 16'h1234);
        checkOutput("fl_byteValid", bus.byteValid, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle();
        cycle();
        checkOutput("drain_memRead", bus.memRead, 1);
        checkOutput("drain_memAddr", bus.memAddr, 16'h0005);
        checkOutput("drain_level", bus.level, 0);
        checkOutput("drain_byteAddr", bus.byteAddr, 16'h1234);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        checkOutput("drop_memAddr", bus.memAddr, 16'h1234);
        checkOutput("drop_memRead", bus.memRead, 1);
        checkOutput("drop_level", bus.level, 0);
        cycle();
        checkOutput("newpc_level", bus.level, 1);
        checkOutput("newpc_byteData", bus.byteData, 8'h97);
        checkOutput("newpc_byteAddr", bus.byteAddr, 16'h1234);
        checkOutput("newpc_memAddr", bus.memAddr, 16'h1235);

        applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFE);
        cycle();
        checkOutput("flack_level", bus.level, 0);
        checkOutput("flack_byteAddr", bus.byteAddr, 16'hFFFE);
        checkOutput("flack_memAddr", bus.memAddr, 16'hFFFE);
        checkOutput("flack_memRead", bus.memRead, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        checkOutput("wrap1_byteData", bus.byteData, 8'h10);
        checkOutput("wrap1_byteAddr", bus.byteAddr, 16'hFFFE);
        checkOutput("wrap1_memAddr", bus.memAddr, 16'hFFFF);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        cycle();
        checkOutput("wrap2_level", bus.level, 1);
        checkOutput("wrap2_byteData", bus.byteData, 8'hFF);
        checkOutput("wrap2_byteAddr", bus.byteAddr, 16'hFFFF);
        checkOutput("wrap2_memAddr", bus.memAddr, 16'h0000);
        cycle();
        checkOutput("wrap3_level", bus.level, 1);
        checkOutput("wrap3_byteData", bus.byteData, 8'h11);
        checkOutput("wrap3_byteAddr", bus.byteAddr, 16'h0000);
        checkOutput("wrap3_memAddr", bus.memAddr, 16'h0001);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        cycle();
        checkOutput("fill3_level", bus.level, 3);
        checkOutput("fill3_memAddr", bus.memAddr, 16'h0003);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        cycle();
        checkOutput("pp_level", bus.level, 3);
        checkOutput("pp_byteData", bus.byteData, 8'h22);
        checkOutput("pp_byteAddr", bus.byteAddr, 16'h0001);
        checkOutput("pp_memAddr", bus.memAddr, 16'h0004);
        checkOutput("pp_memRead", bus.memRead, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        checkOutput("pp_full_level", bus.level, 4);
        checkOutput("pp_full_memRead", bus.memRead, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle();
        checkOutput("pop1_byteData", bus.byteData, 8'h33);
        cycle();
        checkOutput("pop2_byteData", bus.byteData, 8'h44);
        checkOutput("pop2_byteAddr", bus.byteAddr, 16'h0003);
        cycle();
        checkOutput("pop3_byteData", bus.byteData, 8'h55);
        checkOutput("pop3_level", bus.level, 1);
        checkOutput("pop3_memAddr", bus.memAddr, 16'h0005);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        cycle();
        checkOutput("midreq_level", bus.level, 3);
        checkOutput("midreq_memRead", bus.memRead, 1);
        checkOutput("midreq_memAddr", bus.memAddr, 16'h0007);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        #2;
        sysResetN = 1'b0;
        #1;
        checkOutput("arst_memRead", bus.memRead, 0);
        checkOutput("arst_level", bus.level, 0);
        checkOutput("arst_byteValid", bus.byteValid, 0);
        checkOutput("arst_memAddr", bus.memAddr, 16'h0000);
        @(negedge sysClock);
        sysResetN = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle();
        checkOutput("restart_memRead", bus.memRead, 1);
        checkOutput("restart_memAddr", bus.memAddr, 16'h0000);
        cycle();
        checkOutput("restart_byteData", bus.byteData, 8'h11);
        checkOutput("restart_byteAddr", bus.byteAddr, 16'h0000);
        checkOutput("restart_level", bus.level, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
